// File: rtl/mas_radix_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
// Holds the operand width, the number of Booth windows per operation,
// the accumulator width and the control FSM state type.
// Optional feature macro used by the top: MAS_RADIX_SKIP_EN.
package mas_radix_pkg;

    localparam int MAS_WIDTH   = 32;
    localparam int MAS_NUM_WIN = 17;
    localparam int MAS_ACC_W   = 66;
    localparam int MAS_CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mas_seq_state_t;

endpackage

// File: rtl/mas_radix_encoder.sv
// Radix-4 Booth partial-product generator.
// Ports:
//   in1  [31:0] multiplicand A
//   in2  [2:0]  Booth window {b[2i+1], b[2i], b[2i-1]}
//   res  [32:0] magnitude of the partial product: 0, A or 2A
//   flag        high when the partial product is negative (-A or -2A)
module mas_radix_encoder
    import mas_radix_pkg::*;
(
    input  logic [MAS_WIDTH-1:0] in1,
    input  logic [2:0]           in2,
    output logic [MAS_WIDTH:0]   res,
    output logic                 flag
);

    // Booth recoding: each window selects 0, +-A or +-2A. Window 111 is
    // treated as +0 so that a zero partial product never carries a sign.
    always_comb begin
        res  = '0;
        flag = 1'b0;
        unique case (in2)
            3'b001, 3'b010: res = {1'b0, in1};
            3'b011:         res = {in1, 1'b0};
            3'b100: begin
                res  = {in1, 1'b0};
                flag = 1'b1;
            end
            3'b101, 3'b110: begin
                res  = {1'b0, in1};
                flag = 1'b1;
            end
            default: begin
                res  = '0;
                flag = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mas_radix_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth window per clock.
// Operands A and B (unsigned) are accepted on an in_valid/in_ready
// handshake, the 64-bit product is returned on out_valid/out_ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   in_a, in_b        32-bit unsigned multiplicand / multiplier
//   out_valid/out_ready product handshake
//   out_prod          64-bit product, registered, held after transfer
//   busy              high while in RUN or DONE
// Optional feature: define MAS_RADIX_SKIP_EN to finish early once all
// remaining multiplier bits are zero (product is unchanged).
module mas_radix_seq_mult
    import mas_radix_pkg::*;
#(
    parameter int WIDTH = MAS_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               busy
);

    localparam int NUM_WIN = MAS_NUM_WIN;
    localparam int CNT_W   = MAS_CNT_W;
    localparam int ACC_W   = MAS_ACC_W;
    localparam int EXT_W   = WIDTH + 3;

    mas_seq_state_t     state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] out_prod_q, out_prod_d;

    logic [EXT_W-1:0]   ext;
    logic [CNT_W:0]     shamt;
    logic [2:0]         window;
    logic [WIDTH:0]     enc_res;
    logic               enc_flag;
    logic [ACC_W-1:0]   partial;
    logic [ACC_W-1:0]   acc_sum;

    // Window extraction: ext carries an implicit b[-1]=0 at bit 0, so
    // window i sits at ext[2i+2:2i].
    always_comb begin
        ext     = {2'b00, b_q, 1'b0};
        shamt   = {cnt_q, 1'b0};
        window  = ext[shamt +: 3];
        partial = {{(ACC_W-WIDTH-1){1'b0}}, enc_res};
        if (enc_flag) begin
            partial = -partial;
        end
        acc_sum = acc_q + (partial << shamt);
    end

    mas_radix_encoder u_encoder (
        .in1  (a_q),
        .in2  (window),
        .res  (enc_res),
        .flag (enc_flag)
    );

    // Control FSM and datapath next-state. The product register is only
    // loaded on the way into DONE so it stays stable through backpressure
    // and keeps its value after the output transfer.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_prod_d = out_prod_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef MAS_RADIX_SKIP_EN
                // The first window is always accumulated; afterwards stop
                // as soon as every multiplier bit still to be scanned is 0.
                if ((cnt_q != '0) && ((ext >> shamt) == '0)) begin
                    out_prod_d = acc_q[2*WIDTH-1:0];
                    state_d    = DONE;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NUM_WIN - 1)) begin
                        out_prod_d = acc_sum[2*WIDTH-1:0];
                        state_d    = DONE;
                    end
                end
`else
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_WIN - 1)) begin
                    out_prod_d = acc_sum[2*WIDTH-1:0];
                    state_d    = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_prod_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_prod_q <= out_prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_prod  = out_prod_q;

endmodule

// File: tb/tb_mas_radix_seq_mult.sv
// Directed testbench for mas_radix_seq_mult (default build, early-finish
// feature off). Expected products are hand-computed constants.
module tb_mas_radix_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int lat;

    mas_radix_seq_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Present one operand pair for a single cycle; expects IDLE.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic [31:0] b);
        checkOutput({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; returns edges seen since the transfer.
    task automatic waitForValid(input string tag, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_valid_seen"}, {63'd0, out_valid}, 64'd1);
    endtask

    // Full operation with out_ready held high, then the return to IDLE.
    task automatic runOp(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        int c;
        out_ready = 1'b1;
        applyStimulus(tag, a, b);
        waitForValid(tag, c);
        lat = c;
        checkOutput({tag, "_prod"}, out_prod, exp);
        tick();
        checkOutput({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        checkOutput({tag, "_prod_kept"}, out_prod, exp);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_busy",      {63'd0, busy},      64'd0);
        checkOutput("reset_out_prod",  out_prod,           64'd0);
        rst = 1'b0;
        tick();

        // 1: small product and the fixed 17-cycle latency
        runOp("t1_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        checkOutput("t1_latency", 64'(lat), 64'd17);

        // 2: all-ones operands
        runOp("t2_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        // 3: top multiplier bit only (window 15 = -2A, window 16 = +A)
        runOp("t3_msb", 32'd2, 32'h8000_0000, 64'h0000_0001_0000_0000);

        // 4: zero multiplier
        runOp("t4_zero", 32'h1234_5678, 32'd0, 64'd0);

        // extra patterns
        runOp("tx_msbsq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        runOp("tx_by1", 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);

        // 5: backpressure in DONE while new operands are offered
        out_ready = 1'b0;
        applyStimulus("t5", 32'h0000_1234, 32'h0000_0010);
        waitForValid("t5", lat);
        checkOutput("t5_prod", out_prod, 64'h0000_0000_0001_2340);
        for (int i = 0; i < 5; i++) begin
            in_a     = 32'hDEAD_0000 + 32'(i);
            in_b     = 32'h0000_BEEF;
            in_valid = 1'b1;
            checkOutput("t5_hold_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            checkOutput("t5_hold_prod",  out_prod,           64'h0000_0000_0001_2340);
            checkOutput("t5_hold_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("t5_idle_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("t5_idle_ready", {63'd0, in_ready},  64'd1);
        runOp("t5_next", 32'd5, 32'd6, 64'd30);
        checkOutput("t5_next_latency", 64'(lat), 64'd17);

        // 6: reset in the middle of RUN (cnt = 8), then a fresh operation
        applyStimulus("t6", 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (8) tick();
        checkOutput("t6_busy_run", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("t6_rst_prod",  out_prod,           64'd0);
        checkOutput("t6_rst_busy",  {63'd0, busy},      64'd0);
        checkOutput("t6_rst_ready", {63'd0, in_ready},  64'd1);
        runOp("t6_7x9", 32'd7, 32'd9, 64'd63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
